// File: rtl/ssd_scan_ctrl.sv
// Scan controller for an 8-digit active-low seven-segment display with a
// double-buffered glyph frame; swaps are deferred to frame boundaries.
module ssd_scan_ctrl #(
    parameter int ON_CYC    = 12000,
    parameter int BLANK_CYC = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       swap_req,
    output logic       swap_ack,
    output logic       frame_start,
    output logic [7:0] dig,
    output logic [7:0] ssd
);
    localparam int MAXC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYC > 0) ? CW'(BLANK_CYC - 1) : '0;
    localparam logic [CW-1:0] CNT_ONE    = 1;
    localparam bit            HAS_BLANK  = (BLANK_CYC > 0);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_BLANK} state_t;

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            front_sel_q, front_sel_d;
    logic            pending_q, pending_d;
    logic [7:0]      buf_q [2][8];
    logic [7:0]      buf_d [2][8];
    logic [7:0]      dig_q, dig_d, ssd_q, ssd_d;
    logic            ack_q, ack_d, fs_q, fs_d;
    logic            last_d;

    // Scan sequencing: digit index and per-state cycle counter.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_ON;
                idx_d   = '0;
                cnt_d   = '0;
            end
            S_ON: begin
                if (cnt_q == ON_LAST) begin
                    cnt_d = '0;
                    if (HAS_BLANK) begin
                        state_d = S_BLANK;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = S_ON;
                    idx_d   = idx_q + 3'd1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!enable) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end
    end

    // Outputs are registered from next-state values, so swap_ack is raised
    // one cycle ahead of the edge that actually flips the front select.
    always_comb begin
        buf_d = buf_q;
        if (wr_en) begin
            buf_d[~front_sel_q][wr_addr] = wr_data;
        end
        front_sel_d = front_sel_q ^ ack_q;
        pending_d   = (pending_q & ~ack_q) | swap_req;
        last_d      = (idx_d == 3'd7) &&
                      (HAS_BLANK ? (state_d == S_BLANK && cnt_d == BLANK_LAST)
                                 : (state_d == S_ON    && cnt_d == ON_LAST));
        ack_d       = pending_d & ((state_d == S_IDLE) | last_d);
        fs_d        = (state_d == S_ON) && (idx_d == 3'd0) && (cnt_d == '0);
        dig_d       = 8'hFF;
        ssd_d       = 8'hFF;
        if (state_d == S_ON) begin
            dig_d = ~(8'h80 >> idx_d);
            ssd_d = buf_d[front_sel_d][idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            front_sel_q <= 1'b0;
            pending_q   <= 1'b0;
            dig_q       <= 8'hFF;
            ssd_q       <= 8'hFF;
            ack_q       <= 1'b0;
            fs_q        <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < 8; e++) begin
                    buf_q[b][e] <= 8'hFF;
                end
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            front_sel_q <= front_sel_d;
            pending_q   <= pending_d;
            dig_q       <= dig_d;
            ssd_q       <= ssd_d;
            ack_q       <= ack_d;
            fs_q        <= fs_d;
            buf_q       <= buf_d;
        end
    end

    assign dig         = dig_q;
    assign ssd         = ssd_q;
    assign swap_ack    = ack_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: two instances (with and without blanking gap) checked
// every cycle against a frame-position model, plus directed vector tables.
module tb_ssd_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0, wr_en = 1'b0, swap_req = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       ack_a, fs_a, ack_b, fs_b;
    logic [7:0] dig_a, ssd_a, dig_b, ssd_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ssd_scan_ctrl #(.ON_CYC(4), .BLANK_CYC(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .swap_req(swap_req), .swap_ack(ack_a), .frame_start(fs_a),
        .dig(dig_a), .ssd(ssd_a));

    ssd_scan_ctrl #(.ON_CYC(4), .BLANK_CYC(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .swap_req(swap_req), .swap_ack(ack_b), .frame_start(fs_b),
        .dig(dig_b), .ssd(ssd_b));

    task automatic chk8(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%b exp=%b at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: position within the frame, two glyph buffers, front
    // select and a pending flag; outputs derived from position arithmetic.
    logic [7:0] m_buf [2][2][8];
    bit         m_run [2], m_sel [2], m_pend [2], m_ack [2], m_fs [2];
    int         m_pos [2];
    logic [7:0] m_dig [2], m_ssd [2];

    task automatic model_reset(input int k);
        m_run[k] = 0; m_sel[k] = 0; m_pend[k] = 0; m_ack[k] = 0; m_fs[k] = 0;
        m_pos[k] = 0; m_dig[k] = 8'hFF; m_ssd[k] = 8'hFF;
        for (int b = 0; b < 2; b++)
            for (int e = 0; e < 8; e++) m_buf[k][b][e] = 8'hFF;
    endtask

    task automatic model_step(input int k, input int on, input int bl);
        int per, slot, w;
        bit exec;
        per  = 8 * (on + bl);
        exec = m_ack[k];
        if (wr_en) m_buf[k][!m_sel[k]][wr_addr] = wr_data;
        if (exec) m_sel[k] = !m_sel[k];
        m_pend[k] = (m_pend[k] && !exec) || swap_req;
        if (!enable) m_run[k] = 0;
        else if (!m_run[k]) begin m_run[k] = 1; m_pos[k] = 0; end
        else m_pos[k] = (m_pos[k] + 1) % per;
        m_ack[k] = m_pend[k] && (!m_run[k] || m_pos[k] == per - 1);
        m_fs[k]  = m_run[k] && m_pos[k] == 0;
        m_dig[k] = 8'hFF;
        m_ssd[k] = 8'hFF;
        if (m_run[k]) begin
            slot = m_pos[k] / (on + bl);
            w    = m_pos[k] % (on + bl);
            if (w < on) begin
                m_dig[k] = ~(8'h80 >> slot);
                m_ssd[k] = m_buf[k][m_sel[k]][slot];
            end
        end
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset(0);
                model_reset(1);
            end else begin
                model_step(0, 4, 2);
                model_step(1, 4, 0);
            end
        end
    end

    always @(negedge clk) begin
        chk8("dig_a", dig_a, m_dig[0]);
        chk8("ssd_a", ssd_a, m_ssd[0]);
        chk1("ack_a", ack_a, m_ack[0]);
        chk1("fs_a", fs_a, m_fs[0]);
        chk8("dig_b", dig_b, m_dig[1]);
        chk8("ssd_b", ssd_b, m_ssd[1]);
        chk1("ack_b", ack_b, m_ack[1]);
        chk1("fs_b", fs_b, m_fs[1]);
    end

    typedef struct packed {
        int         cyc;
        logic [7:0] dig;
        logic [7:0] ssd;
        logic       fs;
    } vec_t;

    vec_t       tbl [12];
    logic [7:0] glyph [8];

    task automatic wait_dig_a(input logic [7:0] v, input string nm);
        int n = 0;
        while (dig_a !== v && n < 300) begin @(negedge clk); n++; end
        chk1(nm, dig_a === v, 1'b1);
    endtask

    task automatic wait_fs_a(input string nm);
        int n = 0;
        while (fs_a !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        chk1(nm, fs_a, 1'b1);
    endtask

    task automatic wait_ack_a(input string nm);
        int n = 0;
        while (ack_a !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        chk1(nm, ack_a, 1'b1);
    endtask

    initial begin
        int cur, n, cnt;
        tbl[0]  = '{cyc: 0,  dig: 8'h7F, ssd: 8'hFF, fs: 1'b1};
        tbl[1]  = '{cyc: 1,  dig: 8'h7F, ssd: 8'hFF, fs: 1'b0};
        tbl[2]  = '{cyc: 3,  dig: 8'h7F, ssd: 8'hFF, fs: 1'b0};
        tbl[3]  = '{cyc: 4,  dig: 8'hFF, ssd: 8'hFF, fs: 1'b0};
        tbl[4]  = '{cyc: 5,  dig: 8'hFF, ssd: 8'hFF, fs: 1'b0};
        tbl[5]  = '{cyc: 6,  dig: 8'hBF, ssd: 8'hFF, fs: 1'b0};
        tbl[6]  = '{cyc: 12, dig: 8'hDF, ssd: 8'hFF, fs: 1'b0};
        tbl[7]  = '{cyc: 30, dig: 8'hFB, ssd: 8'hFF, fs: 1'b0};
        tbl[8]  = '{cyc: 42, dig: 8'hFE, ssd: 8'hFF, fs: 1'b0};
        tbl[9]  = '{cyc: 45, dig: 8'hFE, ssd: 8'hFF, fs: 1'b0};
        tbl[10] = '{cyc: 47, dig: 8'hFF, ssd: 8'hFF, fs: 1'b0};
        tbl[11] = '{cyc: 48, dig: 8'h7F, ssd: 8'hFF, fs: 1'b1};
        glyph = '{8'h9F, 8'h9F, 8'h25, 8'h49, 8'h9F, 8'h9F, 8'h03, 8'h0D};

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        chk8("rst_dig", dig_a, 8'hFF);
        chk8("rst_ssd", ssd_a, 8'hFF);
        chk1("rst_ack", ack_a, 1'b0);
        chk1("rst_fs", fs_a, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk8("idle_dig", dig_a, 8'hFF);

        // Scan timing after enable
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cur = 0;
        for (int i = 0; i < 12; i++) begin
            while (cur < tbl[i].cyc) begin @(negedge clk); cur++; end
            chk8($sformatf("t1_dig_%0d", tbl[i].cyc), dig_a, tbl[i].dig);
            chk8($sformatf("t1_ssd_%0d", tbl[i].cyc), ssd_a, tbl[i].ssd);
            chk1($sformatf("t1_fs_%0d", tbl[i].cyc), fs_a, tbl[i].fs);
        end

        // Fill back buffer, swap mid-frame, ack at frame end, new glyphs shown
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = glyph[i];
            @(negedge clk);
        end
        wr_en = 1'b0;
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        wait_ack_a("t2_ack_seen");
        chk8("t2_ack_dig", dig_a, 8'hFF);
        @(negedge clk);
        chk1("t2_fs_after_ack", fs_a, 1'b1);
        cur = 0;
        for (int d = 0; d < 8; d++) begin
            while (cur < d * 6 + 1) begin @(negedge clk); cur++; end
            chk8($sformatf("t2_dig_%0d", d), dig_a, ~(8'h80 >> d));
            chk8($sformatf("t2_ssd_%0d", d), ssd_a, glyph[d]);
        end

        // Merged requests produce exactly one ack
        wait_fs_a("t3_fs");
        repeat (10) @(negedge clk);
        swap_req = 1'b1;
        repeat (3) @(negedge clk);
        swap_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (ack_a === 1'b1) cnt++;
            @(negedge clk);
        end
        chk32("t3_one_ack", cnt, 1);

        // Request on the ack cycle re-arms for the following frame
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        wait_ack_a("t3_ack2");
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        n = 1;
        while (ack_a !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk32("t3_rearm_gap", n, 48);

        // Disable during digit 3, pending swap acks in IDLE, restart at digit 0
        wait_dig_a(8'hEF, "t4_dig3");
        swap_req = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        swap_req = 1'b0;
        chk8("t4_off_dig", dig_a, 8'hFF);
        chk8("t4_off_ssd", ssd_a, 8'hFF);
        chk1("t4_idle_ack", ack_a, 1'b1);
        @(negedge clk);
        chk1("t4_ack_single", ack_a, 1'b0);
        enable = 1'b1;
        @(negedge clk);
        chk8("t4_restart_dig", dig_a, 8'h7F);
        chk1("t4_restart_fs", fs_a, 1'b1);

        // No blanking gap: 32-cycle frame with no dark cycles
        n = 0;
        while (fs_b !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk1("t5_fs_b", fs_b, 1'b1);
        @(negedge clk);
        n = 1; cnt = 0;
        while (fs_b !== 1'b1 && n < 100) begin
            if (dig_b === 8'hFF) cnt++;
            @(negedge clk); n++;
        end
        chk32("t5_period", n, 32);
        chk32("t5_gaps", cnt, 0);

        // Async reset mid digit 5 clears outputs and glyphs
        wait_dig_a(8'hFB, "t6_dig5");
        #2 rst_n = 1'b0;
        #1;
        chk8("t6_rst_dig", dig_a, 8'hFF);
        chk8("t6_rst_ssd", ssd_a, 8'hFF);
        chk8("t6_rst_dig_b", dig_b, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ssd_a !== 8'hFF) cnt++;
        end
        chk32("t6_glyphs_blank", cnt, 0);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            enable   = ($urandom_range(0, 59) != 0);
            wr_en    = ($urandom_range(0, 2) == 0);
            wr_addr  = 3'($urandom_range(0, 7));
            wr_data  = 8'($urandom);
            swap_req = ($urandom_range(0, 15) == 0);
            @(negedge clk);
        end
        enable = 1'b0; wr_en = 1'b0; swap_req = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
